// File: rtl/vga_fb_arbiter_pkg.sv
// Shared defaults and the per-cycle owner encoding for the framebuffer port arbiter.
package vga_pkg;

  localparam int VGA_ADDR_W = 19;
  localparam int VGA_DATA_W = 12;
  localparam int VGA_CNT_W  = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_WR0  = 2'd2,
    OWN_WR1  = 2'd3
  } owner_e;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Bundle of display-fetch, writer, RAM-port and counter signals around the arbiter.
// master = clients and RAM side, slave = the arbiter itself.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12,
  parameter int CNT_W  = 16
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_rdata;
  logic [1:0]        wr_req;
  logic [ADDR_W-1:0] wr_addr0;
  logic [ADDR_W-1:0] wr_addr1;
  logic [DATA_W-1:0] wr_data0;
  logic [DATA_W-1:0] wr_data1;
  logic [1:0]        wr_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              conflict_clr;
  logic [CNT_W-1:0]  conflict_cnt;

  modport master (
    output disp_req, disp_addr, wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
           mem_rdata, conflict_clr,
    input  disp_valid, disp_rdata, wr_ack, mem_addr, mem_we, mem_wdata, conflict_cnt
  );

  modport slave (
    input  disp_req, disp_addr, wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
           mem_rdata, conflict_clr,
    output disp_valid, disp_rdata, wr_ack, mem_addr, mem_we, mem_wdata, conflict_cnt
  );
endinterface

// File: rtl/vga_fb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves only when a grant is issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  // last_q = 1 means writer 1 was served last, so writer 0 wins a tie.
  logic last_q, last_d;

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt[0])      last_d = 1'b0;
    else if (gnt[1]) last_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= 1'b1;
    else          last_q <= last_d;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: display fetch has absolute priority with fixed 2-cycle
// read latency; two writers share the remaining cycles round-robin.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W = VGA_ADDR_W,
  parameter int DATA_W = VGA_DATA_W,
  parameter int CNT_W  = VGA_CNT_W
) (
  input logic             clk,
  input logic             reset_n,
  vga_fb_arbiter_if.slave bus
);

  owner_e            owner;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        vld_q, vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  rr_arb2 u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (bus.wr_req),
    .enable  (!bus.disp_req),
    .gnt     (gnt)
  );

  always_comb begin
    owner = OWN_NONE;
    if (bus.disp_req) owner = OWN_DISP;
    else if (gnt[0])  owner = OWN_WR0;
    else if (gnt[1])  owner = OWN_WR1;
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    case (owner)
      OWN_DISP: mem_addr_d = bus.disp_addr;
      OWN_WR0: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = bus.wr_addr0;
        mem_wdata_d = bus.wr_data0;
      end
      OWN_WR1: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = bus.wr_addr1;
        mem_wdata_d = bus.wr_data1;
      end
      default: ;
    endcase
  end

  // A conflict is any cycle in which a writer is asking while the display owns the port.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.conflict_clr)
      cnt_d = '0;
    else if (bus.disp_req && (bus.wr_req != 2'b00) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  assign vld_d = {vld_q[0], bus.disp_req};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      vld_q       <= 2'b00;
      cnt_q       <= '0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      vld_q       <= vld_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.wr_ack       = gnt;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.disp_valid   = vld_q[1];
  assign bus.disp_rdata   = bus.mem_rdata;
  assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural RAM and a display-read scoreboard.
module tb_vga_fb_arbiter;
  import vga_pkg::*;

  localparam int AW = 19;
  localparam int DW = 12;
  localparam int CW = 16;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

  vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [DW-1:0] ram     [0:1023];
  logic [DW-1:0] ref_mem [0:1023];
  exp_t          q[$];
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  bit            mon_ev;
  int            a0, a1, d0, d1;
  logic [1:0]    exp_ack;

  // Synchronous single-port RAM, read-first.
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[9:0]] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr[9:0]];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      mon_ev = (q.size() > 0) && (q[0].due == cyc);
      chk("disp_valid", {31'd0, bus.disp_valid}, {31'd0, mon_ev});
      if (mon_ev) begin
        chk("disp_rdata", {20'd0, bus.disp_rdata}, {20'd0, q[0].data});
        void'(q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.disp_req     = 1'b0;
    bus.wr_req       = 2'b00;
    bus.conflict_clr = 1'b0;
  endtask

  task automatic disp(input int a);
    bus.disp_req  = 1'b1;
    bus.disp_addr = AW'(a);
    q.push_back('{ref_mem[a], cyc + 2});
  endtask

  initial begin
    idle();
    bus.disp_addr = '0;
    bus.wr_addr0 = '0; bus.wr_addr1 = '0;
    bus.wr_data0 = '0; bus.wr_data1 = '0;
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = DW'(i);
      ref_mem[i] = DW'(i);
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", {13'd0, bus.mem_addr}, 32'd0);
    chk("rst_mem_wdata", {20'd0, bus.mem_wdata}, 32'd0);
    chk("rst_wr_ack", {30'd0, bus.wr_ack}, 32'd0);
    chk("rst_cnt", {16'd0, bus.conflict_cnt}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    step();

    // Display latency, back-to-back reads of 0..9
    for (int i = 0; i < 10; i++) begin
      disp(i);
      step();
    end
    idle();
    repeat (3) step();
    $display("display burst 0..9 issued");

    // Round-robin with both writers continuously requesting
    a0 = 200; d0 = 'h100; a1 = 300; d1 = 'h200;
    exp_ack = 2'b01;
    bus.wr_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      bus.wr_addr0 = AW'(a0); bus.wr_data0 = DW'(d0);
      bus.wr_addr1 = AW'(a1); bus.wr_data1 = DW'(d1);
      #1;
      chk("rr_ack", {30'd0, bus.wr_ack}, {30'd0, exp_ack});
      $display("rr cycle %0d: ack=%b", k, bus.wr_ack);
      if (exp_ack[0]) begin ref_mem[a0] = DW'(d0); a0++; d0++; end
      else            begin ref_mem[a1] = DW'(d1); a1++; d1++; end
      exp_ack = ~exp_ack;
      step();
    end
    idle();
    repeat (3) step();
    chk("rr_ram200", {20'd0, ram[200]}, 32'h100);
    chk("rr_ram201", {20'd0, ram[201]}, 32'h101);
    chk("rr_ram300", {20'd0, ram[300]}, 32'h200);
    chk("rr_ram301", {20'd0, ram[301]}, 32'h201);

    // Priority and conflict counting
    bus.conflict_clr = 1'b1;
    step();
    bus.conflict_clr = 1'b0;
    chk("clr_cnt", {16'd0, bus.conflict_cnt}, 32'd0);
    bus.wr_req = 2'b01; bus.wr_addr0 = AW'(400); bus.wr_data0 = DW'('h444);
    for (int k = 0; k < 5; k++) begin
      disp(10 + k);
      #1;
      chk("prio_noack", {30'd0, bus.wr_ack}, 32'd0);
      step();
    end
    bus.disp_req = 1'b0;
    #1;
    chk("prio_ack", {30'd0, bus.wr_ack}, 32'd1);
    chk("conflict5", {16'd0, bus.conflict_cnt}, 32'd5);
    ref_mem[400] = DW'('h444);
    $display("priority: writer0 acked after display release");
    step();
    idle();
    repeat (3) step();
    chk("prio_ram400", {20'd0, ram[400]}, 32'h444);

    // Read-after-write
    bus.wr_req = 2'b10; bus.wr_addr1 = AW'(100); bus.wr_data1 = DW'('hABC);
    #1;
    chk("raw_ack", {30'd0, bus.wr_ack}, 32'd2);
    ref_mem[100] = DW'('hABC);
    step();
    idle();
    disp(100);
    step();
    bus.disp_req = 1'b0;
    repeat (3) step();
    $display("read-after-write at address 100 issued");

    // Counter saturation, then clear colliding with a conflict
    bus.wr_req = 2'b01; bus.wr_addr0 = AW'(500); bus.wr_data0 = DW'('h555);
    for (int k = 0; k < 70000; k++) begin
      disp(0);
      step();
    end
    disp(0);
    bus.conflict_clr = 1'b1;
    #1;
    chk("sat_cnt", {16'd0, bus.conflict_cnt}, 32'hFFFF);
    step();
    idle();
    #1;
    chk("clr_over_inc", {16'd0, bus.conflict_cnt}, 32'd0);
    repeat (3) step();
    chk("abandon_ram500", {20'd0, ram[500]}, 32'd500);

    // Reset cancels a write already registered on the RAM port
    bus.wr_req = 2'b01; bus.wr_addr0 = AW'(6); bus.wr_data0 = DW'('hDDD);
    #1;
    chk("cancel_ack", {30'd0, bus.wr_ack}, 32'd1);
    step();
    idle();
    #1;
    chk("cancel_we_set", {31'd0, bus.mem_we}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("cancel_we_clr", {31'd0, bus.mem_we}, 32'd0);
    step();
    @(negedge clk) reset_n = 1'b1;
    repeat (2) step();
    chk("cancel_ram6", {20'd0, ram[6]}, 32'd6);

    // Reset with a pending write and two reads in flight
    bus.wr_req = 2'b01; bus.wr_addr0 = AW'(5); bus.wr_data0 = DW'('hFFF);
    disp(1);
    #1;
    chk("mid_noack0", {30'd0, bus.wr_ack}, 32'd0);
    step();
    disp(2);
    #1;
    chk("mid_noack1", {30'd0, bus.wr_ack}, 32'd0);
    reset_n = 1'b0;
    #1;
    q.delete();
    idle();
    #1;
    chk("mid_mem_addr", {13'd0, bus.mem_addr}, 32'd0);
    chk("mid_disp_valid", {31'd0, bus.disp_valid}, 32'd0);
    chk("mid_cnt", {16'd0, bus.conflict_cnt}, 32'd0);
    chk("mid_mem_we", {31'd0, bus.mem_we}, 32'd0);
    repeat (2) step();
    @(negedge clk) reset_n = 1'b1;
    repeat (4) step();
    chk("mid_ram5", {20'd0, ram[5]}, 32'd5);

    // Pointer returns to writer 0 preferred
    bus.wr_req = 2'b11;
    bus.wr_addr0 = AW'(600); bus.wr_data0 = DW'('h600);
    bus.wr_addr1 = AW'(601); bus.wr_data1 = DW'('h601);
    #1;
    chk("post_rst_ack0", {30'd0, bus.wr_ack}, 32'd1);
    step();
    bus.wr_req = 2'b10;
    #1;
    chk("post_rst_ack1", {30'd0, bus.wr_ack}, 32'd2);
    step();
    idle();
    repeat (3) step();
    chk("post_ram600", {20'd0, ram[600]}, 32'h600);
    chk("post_ram601", {20'd0, ram[601]}, 32'h601);

    chk("sb_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
